line_buffer_ctrl: RTL and testbench
===================================

# line_buffer_ctrl

Sequencer for the four-line 3x3 window buffer in the edge-detection datapath. It sits between the camera pixel stream and the four-line buffer block and drives that block's control inputs: write-line selection, read enable, rewind, line reset, window rotation and top-edge zero padding. It also applies backpressure to the pixel stream so that no line is overwritten while a window still needs it. One frame of WIDTH x HEIGHT pixels is processed per start pulse.

## Interface
- WIDTH, 640, pixels per line; must be at least 3.
- HEIGHT, 480, lines per frame; must be at least 3.
- clk  in  1  single clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_frame_start  in  1  one-cycle pulse. Ignored unless the block is in IDLE.
- in_pixel_valid  in  1  upstream pixel is present.
- ou_pixel_ready  out  1  a pixel is accepted when both in_pixel_valid and ou_pixel_ready are high.
- in_proc_ready  in  1  downstream filter can take a window this cycle.
- in_full  in  4  per-line full flags from the buffer.
- ou_data_valid  out  1  write strobe to the buffer (accepted pixel).
- ou_line_en_selection  out  2  line being written.
- ou_rden  out  1  read strobe to the buffer.
- ou_buffer_select  out  2  window rotation base.
- ou_re_read  out  4  per-line read-pointer rewind pulse.
- ou_load_new_frame  out  2  top padding code: 1 zeroes window rows 1 and 2, 2 zeroes row 2, 0 means no padding.
- ou_rst_line  out  4  per-line reset pulse.
- ou_win_valid  out  1  the window on the buffer outputs is valid this cycle.
- ou_frame_done  out  1  one-cycle pulse at end of frame.
- ou_overflow  out  1  sticky error flag. Cleared by rst or in_frame_start.

## Operation
- State machine: IDLE -> CLEAR -> RUN -> ROW_END -> (RUN | DONE) -> IDLE.
- IDLE
  - ou_pixel_ready = 0.
  - in_frame_start moves to CLEAR.
- CLEAR (1 cycle)
  - ou_rst_line = 4'hF.
  - wr_col, wr_row, rd_col and rd_row are zeroed.
  - Moves to RUN.
- Write side (active in RUN and ROW_END)
  - ou_pixel_ready = (wr_row < HEIGHT) && (wr_row < 4 || wr_row <= rd_row + 1).
  - Image row k is stored in line k mod 4.
  - Each accepted pixel increments wr_col. At WIDTH-1, wr_col wraps to 0 and wr_row increments.
  - ou_line_en_selection = wr_row[1:0].
  - ou_data_valid = in_pixel_valid & ou_pixel_ready.
- Read side (RUN): output row r is produced once image row r is complete (wr_row > r).
  - ou_rden = in_proc_ready, subject to that condition.
  - rd_col counts reads 0..WIDTH-1. The read at WIDTH-1 moves to ROW_END.
  - ou_buffer_select = (r < 2) ? 0 : (r-2) mod 4.
  - ou_load_new_frame = 1 for r = 0, 2 for r = 1, 0 for r >= 2.
  - The padding code is held for the whole row.
- ROW_END (1 cycle)
  - ou_re_read pulses the lines holding image rows r-1 and r. Lines for r-1 < 0 are omitted.
  - If r >= 2, ou_rst_line pulses line (r-2) mod 4, which frees that line for image row r+2.
  - rd_row increments and rd_col clears.
  - If r = HEIGHT-1, go to DONE; otherwise return to RUN.
- DONE (1 cycle)
  - ou_frame_done = 1 and ou_rst_line = 4'hF.
  - Moves to IDLE.
- A write to line L while in_full[L] = 1 sets ou_overflow. Operation continues.
- Writes and reads may occur in the same cycle on different lines. ROW_END never stalls writes.
- Bottom edge: no padding. The frame ends after output row HEIGHT-1.

## Timing
- Reset values: state IDLE, all counters 0, every output 0.
- rst asserted mid-frame returns to IDLE on the next edge. No ou_frame_done is issued.
- The control outputs are combinational from registered state.
- ou_win_valid = ou_rden registered once, because the buffer's read latency is 1 cycle.
- ou_rst_line and ou_re_read pulses are exactly 1 cycle wide.
- Counter widths: $clog2(WIDTH) for columns and $clog2(HEIGHT+1) for rows.
- Row arithmetic that uses mod 4 takes the two LSBs.

## Structure
- Shared package holds:
  - the state enum (ST_IDLE, ST_CLEAR, ST_RUN, ST_ROW_END, ST_DONE);
  - the padding codes PAD_NONE=0, PAD_ROW12=1, PAD_ROW2=2.
- Single module; no sub-module needed. The write counter and the read sequencer are separate always blocks.

## Test plan
- Reset: assert rst for 3 cycles -> every output is 0 and state is IDLE; in_pixel_valid has no effect.
- Frame start, WIDTH=8, HEIGHT=6, continuous stream with in_proc_ready=1:
  - CLEAR cycle shows ou_rst_line=4'hF.
  - Row 0 is read with load_new_frame=1 and buffer_select=0.
  - Row 1 is read with load_new_frame=2 and buffer_select=0.
  - Row 2 is read with load_new_frame=0 and buffer_select=0.
  - Rows 3 to 5 are read with buffer_select 1, 2, 3.
  - 48 ou_win_valid pulses in total, then ou_frame_done.
- Backpressure: hold in_proc_ready=0 after row 3 is written -> ou_pixel_ready drops before image row 4 and no line is overwritten.
- ROW_END after output row 3 -> ou_re_read=4'b1100 and ou_rst_line=4'b0010.
- Overflow: force in_full[0]=1 while writing line 0 -> ou_overflow sets and stays set until the next in_frame_start.
- Mid-frame rst at output row 2 -> next cycle is IDLE with outputs 0; a new in_frame_start then completes a full frame correctly.

Source files
------------

// File: rtl/line_buffer_ctrl_pkg.sv
// Shared types for the four-line window buffer sequencer.
// State encoding, top padding codes and a line one-hot helper.
package line_buffer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_ROW_END,
        ST_DONE
    } state_e;

    localparam logic [1:0] PAD_NONE  = 2'd0;
    localparam logic [1:0] PAD_ROW12 = 2'd1;
    localparam logic [1:0] PAD_ROW2  = 2'd2;

    function automatic logic [3:0] line_bit(input logic [1:0] line);
        return 4'b0001 << line;
    endfunction

endpackage

// File: rtl/line_buffer_ctrl.sv
// Sequencer for the four-line 3x3 window buffer: write/read/rewind/reset
// control plus stream backpressure so no line is overwritten too early.
import line_buffer_ctrl_pkg::*;

module line_buffer_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_frame_start,
    input  logic       in_pixel_valid,
    output logic       ou_pixel_ready,
    input  logic       in_proc_ready,
    input  logic [3:0] in_full,
    output logic       ou_data_valid,
    output logic [1:0] ou_line_en_selection,
    output logic       ou_rden,
    output logic [1:0] ou_buffer_select,
    output logic [3:0] ou_re_read,
    output logic [1:0] ou_load_new_frame,
    output logic [3:0] ou_rst_line,
    output logic       ou_win_valid,
    output logic       ou_frame_done,
    output logic       ou_overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(HEIGHT);

    state_e state_q, state_d;

    logic [CW-1:0] wr_col_q, wr_col_d;
    logic [RW-1:0] wr_row_q, wr_row_d;
    logic [CW-1:0] rd_col_q, rd_col_d;
    logic [RW-1:0] rd_row_q, rd_row_d;
    logic          win_valid_q;
    logic          ovf_q;

    logic [31:0] wr_row_w;
    logic [31:0] rd_row_w;
    logic        wr_active;
    logic        pix_ready;
    logic        wr_fire;
    logic        rden;
    logic        rd_col_last;
    logic        rd_row_last;
    logic [1:0]  base_line;
    logic [1:0]  pad_code;

    assign wr_row_w = 32'(wr_row_q);
    assign rd_row_w = 32'(rd_row_q);

    // Row k reuses the line of row k-4, last needed by output row k-2.
    assign wr_active = (state_q == ST_RUN) || (state_q == ST_ROW_END);
    assign pix_ready = wr_active && (wr_row_q < ROW_END)
                       && ((wr_row_w < 32'd4) || (wr_row_w <= rd_row_w + 32'd1));
    assign wr_fire   = in_pixel_valid && pix_ready;

    assign rden        = (state_q == ST_RUN) && in_proc_ready && (wr_row_q > rd_row_q);
    assign rd_col_last = (rd_col_q == COL_LAST);
    assign rd_row_last = (rd_row_q == ROW_LAST);

    assign base_line = (rd_row_w < 32'd2) ? 2'd0 : (rd_row_q[1:0] - 2'd2);
    assign pad_code  = (rd_row_w == 32'd0) ? PAD_ROW12 :
                       (rd_row_w == 32'd1) ? PAD_ROW2  : PAD_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (in_frame_start) state_d = ST_CLEAR;
            ST_CLEAR:   state_d = ST_RUN;
            ST_RUN:     if (rden && rd_col_last) state_d = ST_ROW_END;
            ST_ROW_END: state_d = rd_row_last ? ST_DONE : ST_RUN;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_col_d = wr_col_q;
        wr_row_d = wr_row_q;
        if (state_q == ST_CLEAR) begin
            wr_col_d = '0;
            wr_row_d = '0;
        end else if (wr_fire) begin
            if (wr_col_q == COL_LAST) begin
                wr_col_d = '0;
                wr_row_d = wr_row_q + RW'(1);
            end else begin
                wr_col_d = wr_col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_col_q <= '0;
            wr_row_q <= '0;
        end else begin
            wr_col_q <= wr_col_d;
            wr_row_q <= wr_row_d;
        end
    end

    always_comb begin
        rd_col_d = rd_col_q;
        rd_row_d = rd_row_q;
        if (state_q == ST_CLEAR) begin
            rd_col_d = '0;
            rd_row_d = '0;
        end else if (state_q == ST_ROW_END) begin
            rd_col_d = '0;
            rd_row_d = rd_row_q + RW'(1);
        end else if (rden && !rd_col_last) begin
            rd_col_d = rd_col_q + CW'(1);
        end
    end

    // Buffer read latency is one cycle, so the window follows rden by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_col_q    <= '0;
            rd_row_q    <= '0;
            win_valid_q <= 1'b0;
        end else begin
            rd_col_q    <= rd_col_d;
            rd_row_q    <= rd_row_d;
            win_valid_q <= rden;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && in_frame_start) begin
            ovf_q <= 1'b0;
        end else if (wr_fire && in_full[wr_row_q[1:0]]) begin
            ovf_q <= 1'b1;
        end
    end

    always_comb begin
        ou_pixel_ready       = pix_ready;
        ou_data_valid        = wr_fire;
        ou_line_en_selection = wr_active ? wr_row_q[1:0] : 2'd0;
        ou_rden              = rden;
        ou_buffer_select     = 2'd0;
        ou_load_new_frame    = PAD_NONE;
        ou_re_read           = 4'h0;
        ou_rst_line          = 4'h0;
        ou_frame_done        = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                ou_rst_line = 4'hF;
            end
            ST_RUN: begin
                ou_buffer_select  = base_line;
                ou_load_new_frame = pad_code;
            end
            ST_ROW_END: begin
                ou_buffer_select  = base_line;
                ou_load_new_frame = pad_code;
                ou_re_read        = line_bit(rd_row_q[1:0]);
                if (rd_row_w >= 32'd1) begin
                    ou_re_read = ou_re_read | line_bit(rd_row_q[1:0] - 2'd1);
                end
                if (rd_row_w >= 32'd2) begin
                    ou_rst_line = line_bit(rd_row_q[1:0] - 2'd2);
                end
            end
            ST_DONE: begin
                ou_frame_done = 1'b1;
                ou_rst_line   = 4'hF;
            end
            default: begin
                ou_rst_line = 4'h0;
            end
        endcase
    end

    assign ou_win_valid = win_valid_q;
    assign ou_overflow  = ovf_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: random stream/ready traffic against a
// pixel-count reference model plus a line-occupancy scoreboard.
module tb_line_buffer_ctrl;

    localparam int W = 8;
    localparam int H = 6;
    localparam int P_IDLE   = 0;
    localparam int P_CLEAR  = 1;
    localparam int P_RUN    = 2;
    localparam int P_ROWEND = 3;
    localparam int P_DONE   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_frame_start;
    logic       in_pixel_valid;
    logic       in_proc_ready;
    logic [3:0] in_full;
    logic       ou_pixel_ready;
    logic       ou_data_valid;
    logic [1:0] ou_line_en_selection;
    logic       ou_rden;
    logic [1:0] ou_buffer_select;
    logic [3:0] ou_re_read;
    logic [1:0] ou_load_new_frame;
    logic [3:0] ou_rst_line;
    logic       ou_win_valid;
    logic       ou_frame_done;
    logic       ou_overflow;

    int errors = 0;
    int checks = 0;

    // reference model: pixels accepted, current output row, reads in row
    int ph, nwr, r, rcol;
    bit win_e, ovf_e;

    // stimulus knobs
    int pv, pr, pf;
    logic [3:0] fmask;
    bit rst_v, start_v;

    // observation-side scoreboard
    int line_row[4];
    int dv_cnt, rd_cnt, win_cnt, done_cnt;
    int obs_bs[H];
    int obs_lnf[H];
    logic [3:0] cap_re, cap_rl;
    int exp_bs[H];
    int exp_lnf[H];
    int n;

    line_buffer_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_frame_start      (in_frame_start),
        .in_pixel_valid      (in_pixel_valid),
        .ou_pixel_ready      (ou_pixel_ready),
        .in_proc_ready       (in_proc_ready),
        .in_full             (in_full),
        .ou_data_valid       (ou_data_valid),
        .ou_line_en_selection(ou_line_en_selection),
        .ou_rden             (ou_rden),
        .ou_buffer_select    (ou_buffer_select),
        .ou_re_read          (ou_re_read),
        .ou_load_new_frame   (ou_load_new_frame),
        .ou_rst_line         (ou_rst_line),
        .ou_win_valid        (ou_win_valid),
        .ou_frame_done       (ou_frame_done),
        .ou_overflow         (ou_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        dv_cnt = 0; rd_cnt = 0; win_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 4; i++) line_row[i] = -1;
        for (int i = 0; i < H; i++) begin
            obs_bs[i] = 9; obs_lnf[i] = 9;
        end
        cap_re = 4'h0; cap_rl = 4'h0;
    endtask

    // One cycle: drive at negedge, compare at +1, update model, next negedge.
    task automatic step();
        int wrow, row, l;
        bit act, e_rdy, e_dv, e_rden, ok;
        logic [1:0] e_les, e_bs, e_lnf;
        logic [3:0] e_re, e_rl;
        rst = rst_v;
        in_frame_start = start_v;
        in_pixel_valid = ($urandom_range(99) < pv);
        in_proc_ready = ($urandom_range(99) < pr);
        in_full = fmask | (($urandom_range(99) < pf) ? 4'($urandom_range(15)) : 4'h0);
        #1;
        wrow = nwr / W;
        act = (ph == P_RUN) || (ph == P_ROWEND);
        e_rdy = act && (wrow < H) && ((wrow < 4) || (wrow <= r + 1));
        e_dv = e_rdy && in_pixel_valid;
        e_les = act ? 2'(wrow % 4) : 2'd0;
        e_rden = (ph == P_RUN) && in_proc_ready && (wrow > r);
        e_bs = (act && r >= 2) ? 2'((r - 2) % 4) : 2'd0;
        e_lnf = !act ? 2'd0 : (r == 0) ? 2'd1 : (r == 1) ? 2'd2 : 2'd0;
        e_re = 4'h0;
        e_rl = 4'h0;
        if (ph == P_ROWEND) begin
            e_re = 4'(1 << (r % 4));
            if (r >= 1) e_re |= 4'(1 << ((r - 1) % 4));
            if (r >= 2) e_rl = 4'(1 << ((r - 2) % 4));
        end
        if (ph == P_CLEAR || ph == P_DONE) e_rl = 4'hF;
        chk("pixel_ready", ou_pixel_ready, e_rdy);
        chk("data_valid", ou_data_valid, e_dv);
        chk("line_en_sel", ou_line_en_selection, e_les);
        chk("rden", ou_rden, e_rden);
        chk("buffer_select", ou_buffer_select, e_bs);
        chk("load_new_frame", ou_load_new_frame, e_lnf);
        chk("re_read", ou_re_read, e_re);
        chk("rst_line", ou_rst_line, e_rl);
        chk("win_valid", ou_win_valid, win_e);
        chk("frame_done", ou_frame_done, (ph == P_DONE));
        chk("overflow", ou_overflow, ovf_e);
        if (ph == P_ROWEND && r == 3) begin
            cap_re = ou_re_read;
            cap_rl = ou_rst_line;
        end
        // scoreboard driven purely by what the DUT emits
        if (ou_win_valid) win_cnt++;
        if (ou_frame_done) done_cnt++;
        if (ou_rden) begin
            row = rd_cnt / W;
            if (row < H) begin
                obs_bs[row] = ou_buffer_select;
                obs_lnf[row] = ou_load_new_frame;
            end
            ok = 1'b1;
            for (int j = 0; j < 3; j++)
                if (row - j >= 0 && line_row[(row - j) % 4] != row - j) ok = 1'b0;
            chk("window_rows", ok, 1'b1);
            rd_cnt++;
        end
        if (ou_data_valid) begin
            row = dv_cnt / W;
            l = ou_line_en_selection;
            chk("no_overwrite", (line_row[l] == -1) || (line_row[l] == row), 1'b1);
            line_row[l] = row;
            dv_cnt++;
        end
        for (int i = 0; i < 4; i++)
            if (ou_rst_line[i]) line_row[i] = -1;
        // advance reference model
        if (rst_v) begin
            ph = P_IDLE; nwr = 0; r = 0; rcol = 0; win_e = 0; ovf_e = 0;
            for (int i = 0; i < 4; i++) line_row[i] = -1;
            dv_cnt = 0; rd_cnt = 0;
        end else begin
            win_e = e_rden;
            if (e_dv) begin
                if (in_full[wrow % 4]) ovf_e = 1'b1;
                nwr++;
            end
            case (ph)
                P_IDLE: if (start_v) begin ph = P_CLEAR; ovf_e = 1'b0; end
                P_CLEAR: begin ph = P_RUN; nwr = 0; r = 0; rcol = 0; end
                P_RUN: if (e_rden) begin
                    if (rcol == W - 1) ph = P_ROWEND;
                    rcol++;
                end
                P_ROWEND: begin
                    ph = (r == H - 1) ? P_DONE : P_RUN;
                    r++;
                    rcol = 0;
                end
                default: ph = P_IDLE;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic run_frame();
        clear_obs();
        start_v = 1'b1;
        step();
        start_v = 1'b0;
        n = 0;
        while (ph != P_IDLE && n < 3000) begin
            step();
            n++;
        end
        chk("frame_done_count", 8'(done_cnt), 8'd1);
    endtask

    initial begin
        exp_bs = '{0, 0, 0, 1, 2, 3};
        exp_lnf = '{1, 2, 0, 0, 0, 0};
        ph = P_IDLE; nwr = 0; r = 0; rcol = 0; win_e = 0; ovf_e = 0;
        pv = 100; pr = 100; pf = 0; fmask = 4'h0;
        rst_v = 1'b1; start_v = 1'b0;
        rst = 1'b1; in_frame_start = 1'b0; in_pixel_valid = 1'b1;
        in_proc_ready = 1'b0; in_full = 4'h0;
        clear_obs();
        @(negedge clk);
        // reset held 3 cycles with a valid stream present
        step();
        step();
        rst_v = 1'b0;
        step();
        step();
        chk("reset_no_accept", 8'(dv_cnt), 8'd0);

        // continuous stream, sink always ready
        run_frame();
        chk("win_pulses", 8'(win_cnt), 8'(W * H));
        for (int i = 0; i < H; i++) begin
            chk($sformatf("row%0d_bsel", i), 8'(obs_bs[i]), 8'(exp_bs[i]));
            chk($sformatf("row%0d_pad", i), 8'(obs_lnf[i]), 8'(exp_lnf[i]));
        end
        chk("rowend3_re_read", cap_re, 8'b1100);
        chk("rowend3_rst_line", cap_rl, 8'b0010);

        // backpressure: sink stalled, rows 0..3 fit, row 4 must wait
        pr = 0;
        clear_obs();
        start_v = 1'b1;
        step();
        start_v = 1'b0;
        for (int i = 0; i < 60; i++) step();
        chk("bp_accepted", 8'(dv_cnt), 8'(4 * W));
        chk("bp_ready_low", ou_pixel_ready, 1'b0);
        pr = 100;
        n = 0;
        while (ph != P_IDLE && n < 3000) begin
            step();
            n++;
        end
        chk("bp_win_pulses", 8'(win_cnt), 8'(W * H));

        // overflow: line 0 reported full throughout the frame
        fmask = 4'b0001;
        run_frame();
        fmask = 4'h0;
        for (int i = 0; i < 3; i++) step();
        chk("ovf_sticky", ou_overflow, 1'b1);
        run_frame();
        chk("ovf_cleared", ou_overflow, 1'b0);

        // random traffic frames
        for (int f = 0; f < 3; f++) begin
            pv = 40 + $urandom_range(50);
            pr = 30 + $urandom_range(60);
            pf = 10;
            run_frame();
            chk("rand_win_pulses", 8'(win_cnt), 8'(W * H));
        end
        pf = 0;

        // reset in the middle of output row 2
        pv = 100; pr = 100;
        clear_obs();
        start_v = 1'b1;
        step();
        start_v = 1'b0;
        n = 0;
        while (!(ph == P_RUN && r == 2) && n < 500) begin
            step();
            n++;
        end
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        chk("midrst_ready", ou_pixel_ready, 1'b0);
        chk("midrst_rden", ou_rden, 1'b0);
        chk("midrst_win", ou_win_valid, 1'b0);
        chk("midrst_pad", ou_load_new_frame, 2'd0);
        step();
        chk("midrst_no_done", 8'(done_cnt), 8'd0);
        run_frame();
        chk("post_rst_win_pulses", 8'(win_cnt), 8'(W * H));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
